// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizing for the physical register free list.
package rename_pkg;
   localparam int NUM_PREGS = 128;
   localparam int NUM_AREGS = 32;
   localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
   localparam int NUM_CKPT  = 4;
   localparam int TAG_W     = $clog2(NUM_PREGS);
   localparam int CKPT_W    = $clog2(NUM_CKPT);
   localparam int CNT_W     = $clog2(FL_DEPTH + 1);
   localparam int PTR_W     = $clog2(FL_DEPTH);

   typedef logic [TAG_W-1:0]  preg_tag_t;
   typedef logic [CKPT_W-1:0] ckpt_id_t;
   typedef logic [CNT_W-1:0]  fl_cnt_t;
   typedef logic [PTR_W-1:0]  fl_ptr_t;

   // Depth is not a power of two, so the wrap needs an explicit compare.
   function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t p);
      return (p == fl_ptr_t'(FL_DEPTH - 1)) ? '0 : p + fl_ptr_t'(1);
   endfunction
endpackage

// File: rtl/fl_ckpt_slot.sv
// One branch checkpoint of the free list: saved read pointer plus the number
// of grants made since the snapshot, which is what a recover gives back.
module fl_ckpt_slot
   import rename_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    take,
   input  logic    drop,
   input  logic    inc,
   input  logic    kill,
   input  fl_ptr_t head_in,
   output logic    valid,
   output fl_ptr_t head_ck,
   output fl_cnt_t since
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
      end else if (take) begin
         valid <= 1'b1;
      end else if (drop || kill) begin
         valid <= 1'b0;
      end
   end

   // Payload is only consulted while valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (take) begin
         head_ck <= head_in;
         since   <= '0;
      end else if (inc && valid) begin
         since   <= since + fl_cnt_t'(1);
      end
   end

endmodule

// File: rtl/preg_free_list.sv
// Physical register free list: one grant and one return per cycle, with
// per-branch checkpoints that restore the read pointer in a single cycle.
module preg_free_list
   import rename_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                alloc_req,
   output logic                alloc_valid,
   output preg_tag_t           alloc_tag,
   output logic                set_not_rdy,
   output preg_tag_t           not_rdy_tag,
   input  logic                free_en,
   input  preg_tag_t           free_tag,
   input  logic                ckpt_take,
   input  ckpt_id_t            ckpt_id,
   input  logic                ckpt_release,
   input  logic                recover,
   input  ckpt_id_t            recover_id,
   input  logic [NUM_CKPT-1:0] recover_kill,
   output logic                ckpt_full,
   output fl_cnt_t             free_count,
   output logic                overflow_err
);

   preg_tag_t entries [FL_DEPTH];
   fl_ptr_t   head;
   fl_ptr_t   tail;
   fl_cnt_t   count;

   logic [NUM_CKPT-1:0] ck_valid;
   fl_ptr_t             ck_head  [NUM_CKPT];
   fl_cnt_t             ck_since [NUM_CKPT];

   logic           alloc_fire;
   logic           free_hit;
   logic           free_acc;
   logic           free_drop;
   logic           rec_ok;
   logic           rec_bad;
   logic           take_eff;
   fl_ptr_t        head_post;
   logic [CNT_W:0] rec_count;

   assign alloc_valid  = (count != '0) && !recover;
   assign alloc_fire   = alloc_req && alloc_valid;
   assign alloc_tag    = entries[head];
   assign set_not_rdy  = alloc_fire;
   assign not_rdy_tag  = alloc_tag;
   assign free_count   = count;
   assign ckpt_full    = &ck_valid;

   assign free_hit  = free_en && (free_tag != '0);
   assign free_acc  = free_hit && (count != fl_cnt_t'(FL_DEPTH));
   assign free_drop = free_hit && !free_acc;
   assign rec_ok    = recover && ck_valid[recover_id];
   assign rec_bad   = recover && !ck_valid[recover_id];
   assign take_eff  = ckpt_take && !recover;
   assign head_post = alloc_fire ? fl_ptr_inc(head) : head;

   // Everything granted since the snapshot comes back, plus a same-cycle return.
   assign rec_count = (CNT_W+1)'(count) + (CNT_W+1)'(ck_since[recover_id])
                    + (CNT_W+1)'(free_acc);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            entries[i] <= preg_tag_t'(NUM_AREGS + i);
         end
      end else if (free_acc) begin
         entries[tail] <= free_tag;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head         <= '0;
         tail         <= '0;
         count        <= fl_cnt_t'(FL_DEPTH);
         overflow_err <= 1'b0;
      end else begin
         if (free_acc) begin
            tail <= fl_ptr_inc(tail);
         end
         if (rec_ok) begin
            head  <= ck_head[recover_id];
            count <= rec_count[CNT_W-1:0];
         end else begin
            head  <= head_post;
            count <= count + fl_cnt_t'(free_acc) - fl_cnt_t'(alloc_fire);
         end
         if (free_drop || rec_bad) begin
            overflow_err <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_CKPT; k++) begin : g_ckpt
      logic sel;
      logic kill;
      assign sel  = (ckpt_id == ckpt_id_t'(k));
      assign kill = rec_ok && ((recover_id == ckpt_id_t'(k)) || recover_kill[k]);

      fl_ckpt_slot u_slot (
         .clk     (clk),
         .reset   (reset),
         .take    (take_eff && sel),
         .drop    (ckpt_release && sel),
         .inc     (alloc_fire),
         .kill    (kill),
         .head_in (head_post),
         .valid   (ck_valid[k]),
         .head_ck (ck_head[k]),
         .since   (ck_since[k])
      );
   end

endmodule
